// File: rtl/lsu_align_unit_if.sv
// Request, data-memory and response signals of lsu_align_unit.
// slave is the alignment unit's view; master is the core/memory side.
interface lsu_align_unit_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  localparam int B = DWIDTH / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;

  logic              mem_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [B-1:0]      mem_wen;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_ack;

  logic              resp_valid;
  logic [DWIDTH-1:0] resp_rdata;
  logic              resp_err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, mem_en, mem_addr, mem_wen, mem_wdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, mem_en, mem_addr, mem_wen, mem_wdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align_unit.sv
// Load/store lane alignment between the memory stage and the data-memory port.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two aligned beats.
module lsu_align_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  lsu_align_unit_if.slave lsu_if
);
  // state | meaning
  // IDLE  | ready to accept a request
  // BEAT0 | first (or only) aligned memory beat
  // BEAT1 | upper beat of a word-crossing access (split build only)
  // RESP  | one-cycle completion pulse carrying load data
  // ERR   | one-cycle error pulse, no memory traffic

  localparam int B    = DWIDTH / 8;
  localparam int OFFW = $clog2(B);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store)
      ok = (f3 inside {3'b000, 3'b001, 3'b010}) || (DWIDTH == 64 && f3 == 3'b011);
    else
      ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
           (DWIDTH == 64 && (f3 == 3'b011 || f3 == 3'b110));
    return !ok;
  endfunction

  function automatic logic crosses_word(input logic [OFFW-1:0] off, input logic [1:0] sz);
    logic [4:0] span;
    span = 5'(off) + (5'd1 << sz);
    return span > 5'(B);
  endfunction

  state_e            state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] lo_buf_q;

  logic [OFFW-1:0]   off;
  logic [AWIDTH-1:0] base_addr;
  logic [B-1:0]      lane_mask;
  logic [B-1:0]      wen_beat0;
  logic [DWIDTH-1:0] wdata_beat0;
  logic [DWIDTH-1:0] rd_shifted;
  logic [DWIDTH-1:0] load_result;
  logic              sign_bit;
  logic              req_err;

  logic              req_ready;
  logic              mem_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [B-1:0]      mem_wen;
  logic [DWIDTH-1:0] mem_wdata;
  logic              resp_valid;
  logic [DWIDTH-1:0] resp_rdata;
  logic              resp_err;

  assign off       = addr_q[OFFW-1:0];
  assign base_addr = {addr_q[AWIDTH-1:OFFW], {OFFW{1'b0}}};

  always_comb begin
    for (int i = 0; i < B; i++)
      lane_mask[i] = (i < (1 << funct3_q[1:0]));
  end

`ifdef MISALIGN_SPLIT_EN
  logic [DWIDTH-1:0] hi_buf_q;
  logic [B-1:0]      wen_beat1;
  logic [DWIDTH-1:0] wdata_beat1;
  logic              is_split;

  // Shifting into a double-width vector yields both beats at once: low half
  // is the lower word, high half spills into the next word.
  assign {wen_beat1, wen_beat0}     = {{B{1'b0}}, lane_mask} << off;
  assign {wdata_beat1, wdata_beat0} = {{DWIDTH{1'b0}}, wdata_q} << {off, 3'b000};
  assign rd_shifted = DWIDTH'({hi_buf_q, lo_buf_q} >> {off, 3'b000});
  assign is_split   = crosses_word(off, funct3_q[1:0]);
  assign req_err    = f3_illegal(lsu_if.req_is_store, lsu_if.req_funct3);
`else
  assign wen_beat0   = lane_mask << off;
  assign wdata_beat0 = wdata_q << {off, 3'b000};
  assign rd_shifted  = lo_buf_q >> {off, 3'b000};
  assign req_err     = f3_illegal(lsu_if.req_is_store, lsu_if.req_funct3) ||
                       crosses_word(lsu_if.req_addr[OFFW-1:0], lsu_if.req_funct3[1:0]);
`endif

  always_comb begin
    sign_bit = 1'b0;
    case (funct3_q[1:0])
      2'd0:    sign_bit = rd_shifted[7];
      2'd1:    sign_bit = rd_shifted[15];
      2'd2:    sign_bit = rd_shifted[31];
      default: sign_bit = rd_shifted[DWIDTH-1];
    endcase
    sign_bit = sign_bit & ~funct3_q[2];
    for (int i = 0; i < DWIDTH; i++)
      load_result[i] = (i < (8 << funct3_q[1:0])) ? rd_shifted[i] : sign_bit;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_wen    = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (lsu_if.req_valid) state_d = req_err ? S_ERR : S_BEAT0;
      end
      S_BEAT0: begin
        mem_en    = 1'b1;
        mem_addr  = base_addr;
        mem_wen   = is_store_q ? wen_beat0 : '0;
        mem_wdata = wdata_beat0;
        if (lsu_if.mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
          state_d = is_split ? S_BEAT1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_BEAT1: begin
        mem_en    = 1'b1;
        mem_addr  = base_addr + AWIDTH'(B);
        mem_wen   = is_store_q ? wen_beat1 : '0;
        mem_wdata = wdata_beat1;
        if (lsu_if.mem_ack) state_d = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = is_store_q ? '0 : load_result;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_buf_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
      hi_buf_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && lsu_if.req_valid) begin
        is_store_q <= lsu_if.req_is_store;
        funct3_q   <= lsu_if.req_funct3;
        addr_q     <= lsu_if.req_addr;
        wdata_q    <= lsu_if.req_wdata;
      end
      if (state_q == S_BEAT0 && lsu_if.mem_ack) lo_buf_q <= lsu_if.mem_rdata;
`ifdef MISALIGN_SPLIT_EN
      if (state_q == S_BEAT1 && lsu_if.mem_ack) hi_buf_q <= lsu_if.mem_rdata;
`endif
    end
  end

  assign lsu_if.req_ready  = req_ready;
  assign lsu_if.mem_en     = mem_en;
  assign lsu_if.mem_addr   = mem_addr;
  assign lsu_if.mem_wen    = mem_wen;
  assign lsu_if.mem_wdata  = mem_wdata;
  assign lsu_if.resp_valid = resp_valid;
  assign lsu_if.resp_rdata = resp_rdata;
  assign lsu_if.resp_err   = resp_err;
endmodule

// File: tb/tb_lsu_align_unit.sv
// Scoreboard bench for lsu_align_unit (DWIDTH = 32): stimulus pushes expected
// beats and responses; a memory model and a response monitor pop and compare.
module tb_lsu_align_unit;
  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
    int            acc;
  } resp_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] wen;
    logic [DW-1:0]   wdata;
  } beat_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   resp_cnt = 0;
  int   ack_delay = 0;

  resp_t         exp_resp[$];
  beat_t         exp_beats[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  lsu_align_unit_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
  lsu_align_unit #(.DWIDTH(DW), .AWIDTH(AW)) dut (.clk(clk), .rst(rst), .lsu_if(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic push_beat(input logic [AW-1:0] a, input logic [3:0] wen, input logic [DW-1:0] wd);
    exp_beats.push_back('{addr: a, wen: wen, wdata: wd});
  endtask

  // Waits (bounded) for req_ready, then presents the request for one cycle.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit has_resp, input logic e_err,
                       input logic [DW-1:0] e_rd, input int lat);
    int g = 0;
    while (!bus.req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got req_ready 0, expected 1 within 200 cycles");
      return;
    end
    if (has_resp) exp_resp.push_back('{err: e_err, rdata: e_rd, lat: lat, acc: cyc});
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_resp.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  // Memory model: checks each new beat against the expected queue, checks it
  // stays stable, and acks after ack_delay cycles even if the unit is reset.
  initial begin : mem_model
    logic  in_beat;
    int    cnt;
    beat_t cur;
    beat_t e;
    in_beat       = 1'b0;
    cnt           = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      if (!in_beat && bus.mem_en) begin
        if (exp_beats.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_unexpected: got mem_en at addr %0h, expected no beat", bus.mem_addr);
        end else begin
          e = exp_beats.pop_front();
          check("beat_addr", bus.mem_addr, e.addr);
          check("beat_wen", bus.mem_wen, e.wen);
          check("beat_wdata", bus.mem_wdata, e.wdata);
        end
        cur     = '{addr: bus.mem_addr, wen: bus.mem_wen, wdata: bus.mem_wdata};
        in_beat = 1'b1;
        cnt     = ack_delay;
      end else if (in_beat && bus.mem_en) begin
        check("beat_stable", {bus.mem_addr, bus.mem_wen, bus.mem_wdata[27:0]},
              {cur.addr, cur.wen, cur.wdata[27:0]});
      end
      if (in_beat) begin
        if (cnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem.exists(cur.addr) ? mem[cur.addr] : '0;
          in_beat       = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        resp_cnt++;
        if (exp_resp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL resp_unexpected: got resp_valid err=%0b rdata=%0h, expected none",
                   bus.resp_err, bus.resp_rdata);
        end else begin
          e = exp_resp.pop_front();
          check("resp_err", bus.resp_err, e.err);
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int            g;
    int            rc;
    logic [AW-1:0] target;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    mem[32'h2000] = 32'h12803456;
    mem[32'h2004] = 32'h000000AB;
    mem[32'h3000] = 32'h44332211;
    mem[32'h3004] = 32'h88776655;
    mem[32'h5000] = 32'h00F00000;
    mem[32'h7000] = 32'hCAFEF00D;
    mem[32'h9000] = 32'h5555AAAA;

    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wen", bus.mem_wen, 4'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_rdata}, 34'h0);
    rst = 1'b0;
    @(negedge clk);

    // SB, LH, LHU
    push_beat(32'h1000, 4'b1000, 32'hDD000000);
    issue(1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 1, 1'b0, 32'h0, 2);
    push_beat(32'h2000, 4'b0000, 32'h0);
    issue(1'b0, 3'b001, 32'h2001, 32'h0, 1, 1'b0, 32'hFFFF8034, 2);
    push_beat(32'h2000, 4'b0000, 32'h0);
    issue(1'b0, 3'b101, 32'h2001, 32'h0, 1, 1'b0, 32'h00008034, 2);

    // word-crossing accesses
`ifdef MISALIGN_SPLIT_EN
    push_beat(32'h3000, 4'b0000, 32'h0);
    push_beat(32'h3004, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h3002, 32'h0, 1, 1'b0, 32'h66554433, 3);
    push_beat(32'h3000, 4'b1000, 32'hD4000000);
    push_beat(32'h3004, 4'b0111, 32'h00A1B2C3);
    issue(1'b1, 3'b010, 32'h3003, 32'hA1B2C3D4, 1, 1'b0, 32'h0, 3);
    push_beat(32'h2000, 4'b0000, 32'h0);
    push_beat(32'h2004, 4'b0000, 32'h0);
    issue(1'b0, 3'b001, 32'h2003, 32'h0, 1, 1'b0, 32'hFFFFAB12, 3);
`else
    issue(1'b0, 3'b010, 32'h3002, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b010, 32'h3003, 32'hA1B2C3D4, 1, 1'b1, 32'h0, 1);
    issue(1'b0, 3'b001, 32'h2003, 32'h0, 1, 1'b1, 32'h0, 1);
`endif

    // illegal funct3 for a 32-bit unit
    issue(1'b0, 3'b111, 32'h4000, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b100, 32'h8000, 32'h12345678, 1, 1'b1, 32'h0, 1);
    issue(1'b0, 3'b011, 32'h8000, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(1'b0, 3'b110, 32'h8000, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b011, 32'h8000, 32'h12345678, 1, 1'b1, 32'h0, 1);

    // LB / LBU sign handling, SH lanes, aligned SW
    push_beat(32'h5000, 4'b0000, 32'h0);
    issue(1'b0, 3'b000, 32'h5002, 32'h0, 1, 1'b0, 32'hFFFFFFF0, 2);
    push_beat(32'h5000, 4'b0000, 32'h0);
    issue(1'b0, 3'b100, 32'h5002, 32'h0, 1, 1'b0, 32'h000000F0, 2);
    push_beat(32'h6000, 4'b1100, 32'hBEEF0000);
    issue(1'b1, 3'b001, 32'h6002, 32'h0000BEEF, 1, 1'b0, 32'h0, 2);
    push_beat(32'h8000, 4'b1111, 32'h01020304);
    issue(1'b1, 3'b010, 32'h8000, 32'h01020304, 1, 1'b0, 32'h0, 2);

    // memory wait states
    wait_drain();
    ack_delay = 3;
    push_beat(32'h7000, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h7000, 32'h0, 1, 1'b0, 32'hCAFEF00D, 5);
    wait_drain();

    // reset while a beat waits for a late ack
    ack_delay = 5;
`ifdef MISALIGN_SPLIT_EN
    push_beat(32'h3000, 4'b0000, 32'h0);
    push_beat(32'h3004, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h3002, 32'h0, 0, 1'b0, 32'h0, 0);
    target = 32'h3004;
`else
    push_beat(32'h9000, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h9000, 32'h0, 0, 1'b0, 32'h0, 0);
    target = 32'h9000;
`endif
    g = 0;
    while (!(bus.mem_en === 1'b1 && bus.mem_addr === target) && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("rst_beat_reached", bus.mem_addr, target);
    repeat (2) @(negedge clk);
    rc  = resp_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mem_en", bus.mem_en, 1'b0);
    check("midrst_req_ready", bus.req_ready, 1'b1);
    check("midrst_resp_valid", bus.resp_valid, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_resp", resp_cnt, rc);
    ack_delay = 0;

    // recovery after reset
    push_beat(32'h7000, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h7000, 32'h0, 1, 1'b0, 32'hCAFEF00D, 2);
    wait_drain();
    repeat (3) @(negedge clk);
    check("resp_queue_empty", exp_resp.size(), 0);
    check("beat_queue_empty", exp_beats.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_align_unit.md
# lsu_align_unit

- Parametrised load/store alignment unit between the core's memory stage and the data-memory port.
- Accepts one load or store per handshake and drives lane-shifted write enables and write data.
- Returns sign- or zero-extended load data.
- When the split feature is compiled in, it breaks a misaligned access that crosses a word boundary into two aligned memory beats.
- Memory latency is variable: every beat completes on a memory acknowledge.

## Interface
Parameters:
- DWIDTH, 32: memory word width in bits; legal values 32 or 64. B = DWIDTH/8 byte lanes; OFFW = log2(B).
- AWIDTH, 32: byte-address width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
- req_addr  in  AWIDTH  byte address.
- req_wdata  in  DWIDTH  store data, right-justified.
- mem_en  out  1  memory beat active.
- mem_addr  out  AWIDTH  aligned beat address; low OFFW bits are 0.
- mem_wen  out  B  per-lane write enable; 0 for loads.
- mem_wdata  out  DWIDTH  lane-shifted store data.
- mem_rdata  in  DWIDTH  read data; valid when mem_ack is high.
- mem_ack  in  1  beat complete, for loads and stores.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  DWIDTH  extended load result; 0 for stores and errors.
- resp_err  out  1  access rejected; qualified by resp_valid.

## Operation
- Size: bytes = 1 << funct3[1:0]. Off = req_addr[OFFW-1:0]. A request is split when off + bytes > B.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - When DWIDTH = 64, load 011 and 110 and store 011 are also legal.
  - Anything else sets err.
- States:
  - IDLE: req_ready = 1. On accept, latch the request. Go to ERR if err, else to BEAT0.
  - BEAT0: address = req_addr with the low OFFW bits cleared.
    - mem_wen = lane mask << off, truncated to B bits.
    - mem_wdata = req_wdata << 8·off.
    - On mem_ack, capture mem_rdata into lo_buf. Go to BEAT1 if split, else to RESP.
  - BEAT1: address = BEAT0 address + B.
    - mem_wen = lane mask >> (B − off).
    - mem_wdata = req_wdata >> 8·(B − off).
    - On mem_ack, capture mem_rdata into hi_buf and go to RESP.
  - RESP: resp_valid = 1 for one cycle, then go to IDLE.
    - Load result = ({hi_buf, lo_buf} >> 8·off) truncated to `bytes` bytes, then extended.
    - Extension is zero for funct3[2] = 1, sign otherwise.
  - ERR: resp_valid = 1 and resp_err = 1 for one cycle, no memory beat, then go to IDLE.
- mem_en, mem_addr, mem_wen and mem_wdata are held stable throughout a beat until mem_ack.
- mem_ack is ignored in IDLE, RESP and ERR.

## Timing
- Reset values: req_ready = 1; mem_en = 0; mem_wen = 0; mem_addr = 0; mem_wdata = 0; resp_valid = 0; resp_err = 0; resp_rdata = 0; state = IDLE.
- Accept on cycle N means mem_en is high from cycle N+1.
- Unsplit access with mem_ack on cycle N+1: resp_valid on N+2. Minimum latency is 2 cycles.
- Split access with zero-wait memory: BEAT1 on N+2, resp_valid on N+3.
- Error: resp_valid on N+1.
- Back-to-back requests: req_ready returns high the cycle after RESP or ERR, so the throughput floor is one request per 3 cycles.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The in-flight request is dropped with no resp_valid, and a late mem_ack is ignored.
- req_valid while req_ready = 0 is not accepted; the producer must hold it.

## Configuration
- MISALIGN_SPLIT_EN defined: split behaviour exactly as above.
- MISALIGN_SPLIT_EN undefined:
  - Any split access is treated as err and goes to ERR with no memory beat.
  - The BEAT1 state and hi_buf are not built.
  - Non-crossing misaligned accesses (e.g. LH at off 1) still complete in one beat.

## Test plan
All scenarios use DWIDTH = 32.
- SB, addr 0x1003, wdata 0xAABBCCDD → mem_addr 0x1000, mem_wen 1000, mem_wdata 0xDD000000; resp_valid with resp_err = 0.
- LH, addr 0x2001, mem_rdata 0x12803456 → resp_rdata 0xFFFF8034. LHU at the same address → 0x00008034.
- LW, addr 0x3002 (split enabled); beat 0x3000 returns 0x44332211, beat 0x3004 returns 0x88776655 → exactly two mem_en beats; resp_rdata 0x66554433.
- SW, addr 0x3003, wdata 0xA1B2C3D4 → beat0: 0x3000, wen 1000, wdata 0xD4000000. Beat1: 0x3004, wen 0111, wdata 0x00A1B2C3. With split disabled → resp_err = 1 and mem_en never asserted.
- Load with funct3 111 → no mem_en; resp_valid and resp_err on the cycle after accept; resp_rdata 0.
- rst asserted while waiting in BEAT1 with mem_ack delayed 5 cycles → next cycle mem_en 0 and req_ready 1; the late mem_ack produces no resp_valid.
